// File: rtl/device_scheduler.sv
// device_scheduler: round-robin arbiter sharing one start/ready device among four requesters.
module device_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  xin_bus,
  input  logic [8*N_REQ-1:0]   yin_bus,
  output logic                 dev_start,
  output logic [15:0]          dev_xin,
  output logic [7:0]           dev_yin,
  input  logic [15:0]          dev_out,
  input  logic                 dev_ready,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [15:0]          result,
  output logic [1:0]           result_id,
  output logic                 err,
  output logic                 busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_GUARD, S_WAIT, S_DONE} state_t;
  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [1:0]      r_id;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      w_win;
  logic            w_timeout;
  // Scan from the highest offset down so the closest requester to r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
  end
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
  assign busy = r_state != S_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      dev_start <= 1'b0;
      dev_xin   <= '0;
      dev_yin   <= '0;
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      result_id <= '0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (|req) begin
          r_id      <= w_win;
          r_ptr     <= w_win + 2'd1;
          dev_xin   <= xin_bus[16*w_win +: 16];
          dev_yin   <= yin_bus[8*w_win +: 8];
          gnt       <= N_REQ'(1) << w_win;
          dev_start <= 1'b1;
          r_state   <= S_START;
        end
        S_START: begin
          dev_start <= 1'b0;
          r_state   <= S_GUARD;
        end
        // A ready left over from the previous operation is ignored here.
        S_GUARD: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (dev_ready || w_timeout) begin
          result    <= dev_ready ? dev_out : 16'h0000;
          err       <= !dev_ready;
          done      <= gnt;
          result_id <= r_id;
          r_state   <= S_DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          done    <= '0;
          gnt     <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_device_scheduler.sv
// tb_device_scheduler: vector table plus scoreboard check of device_scheduler with a behavioural device.
module tb_device_scheduler;
  localparam int TIMEOUT = 64;
  typedef struct { logic [3:0] req; int mode; int lat; int id; } vec_t;
  typedef struct { int id; logic [15:0] x; logic [7:0] y; logic [15:0] res; logic err; int dt; } exp_t;
  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  req = 0;
  logic [63:0] xin_bus = 0;
  logic [31:0] yin_bus = 0;
  logic        dev_start;
  logic [15:0] dev_xin;
  logic [7:0]  dev_yin;
  logic [15:0] dev_out = 0;
  logic        dev_ready = 0;
  logic [3:0]  gnt, done;
  logic [15:0] result;
  logic [1:0]  result_id;
  logic        err, busy;
  int n_tot = 0, n_fail = 0, n_start = 0, cyc = 0, t_start = 0;
  int mode = 0, lat = 3, dcnt = 0;
  exp_t q[$];

  device_scheduler #(.N_REQ(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .xin_bus(xin_bus), .yin_bus(yin_bus),
    .dev_start(dev_start), .dev_xin(dev_xin), .dev_yin(dev_yin),
    .dev_out(dev_out), .dev_ready(dev_ready), .gnt(gnt), .done(done),
    .result(result), .result_id(result_id), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f(input logic [15:0] x, input logic [7:0] y);
    return x ^ {y, 8'h7E};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tot++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // mode 0: ready pulses lat cycles after start; 1: never ready; 2: ready stuck high
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dev_start) dcnt <= lat;
    else if (dcnt != 0) dcnt <= dcnt - 1;
    dev_ready <= mode == 2 || (mode == 0 && !dev_start && dcnt == 1);
    dev_out   <= f(dev_xin, dev_yin);
  end

  always @(negedge clk) begin
    if (dev_start) begin
      n_start++;
      t_start = cyc;
      if (q.size() != 0) begin
        chk("start_gnt", gnt, 32'(1) << q[0].id);
        chk("start_xin", dev_xin, q[0].x);
        chk("start_yin", dev_yin, q[0].y);
      end
    end
    if (done != 0) begin
      if (q.size() == 0) chk("unexpected_done", done, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done", done, 32'(1) << e.id);
        chk("result_id", result_id, e.id);
        chk("result", result, e.res);
        chk("err", err, e.err);
        chk("xin_stable", dev_xin, e.x);
        chk("latency", cyc - t_start, e.dt);
      end
    end
  end

  task automatic push(input int id);
    exp_t e;
    e.id  = id;
    e.x   = xin_bus[16*id +: 16];
    e.y   = yin_bus[8*id +: 8];
    e.err = mode == 1;
    e.res = mode == 1 ? 16'h0000 : f(e.x, e.y);
    e.dt  = mode == 1 ? TIMEOUT + 2 : mode == 2 ? 3 : lat + 2;
    q.push_back(e);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done != 0) break;
    end
    if (k == 200) begin
      n_tot++;
      n_fail++;
      $display("FAIL done_timeout: no done within 200 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    vec_t tv[8];
    int n0;
    tv = '{'{4'b0001, 0, 3, 0}, '{4'b0001, 0, 2, 0}, '{4'b1001, 0, 4, 3}, '{4'b0110, 0, 1, 1},
           '{4'b0110, 0, 3, 2}, '{4'b0011, 2, 0, 0}, '{4'b1100, 0, 1, 2}, '{4'b1000, 0, 10, 3}};
    repeat (3) @(negedge clk);
    chk("rst_dev_start", dev_start, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_result_id", result_id, 0);
    chk("rst_dev_xin", dev_xin, 0);
    chk("rst_dev_yin", dev_yin, 0);
    rst = 0;
    // every requester active: strict rotation 0,1,2,3,0
    xin_bus = {$urandom, $urandom};
    yin_bus = $urandom;
    mode = 0;
    lat = 2;
    foreach (tv[i]) if (i < 5) push(i % 4);
    n0 = n_start;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done();
      chk("rr_busy", busy, 1);
    end
    req = 0;
    repeat (3) @(negedge clk);
    chk("rr_starts", n_start - n0, 5);
    do_reset(2);
    foreach (tv[i]) begin
      xin_bus = {$urandom, $urandom};
      yin_bus = $urandom;
      if (i == 0) begin
        xin_bus[15:0] = 16'h00C8;
        yin_bus[7:0]  = 8'h00;
      end
      mode = tv[i].mode;
      lat  = tv[i].lat;
      push(tv[i].id);
      req = tv[i].req;
      wait_done();
      if (i == 0) chk("first_result", result, 16'h00B6);
      req = 0;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_gnt", gnt, 0);
    end
    // fairness: requester 1 arrives during service of 2 and must be served next
    mode = 0;
    lat = 3;
    push(2);
    push(1);
    push(2);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    req = 4'b0110;
    wait_done();
    wait_done();
    req = 4'b0100;
    wait_done();
    req = 0;
    repeat (2) @(negedge clk);
    // timeout with the device never answering
    mode = 1;
    push(3);
    req = 4'b1000;
    wait_done();
    req = 0;
    repeat (2) @(negedge clk);
    chk("hold_err", err, 1);
    chk("hold_result_id", result_id, 3);
    // reset while waiting aborts without a done pulse
    req = 4'b0001;
    n0 = n_start;
    for (int k = 0; k < 20 && n_start == n0; k++) @(negedge clk);
    chk("abort_started", n_start - n0, 1);
    repeat (10) @(negedge clk);
    req = 0;
    do_reset(1);
    chk("abort_busy", busy, 0);
    chk("abort_gnt", gnt, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    repeat (5) @(negedge clk);
    mode = 0;
    lat = 2;
    push(1);
    req = 4'b0010;
    wait_done();
    req = 0;
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end
endmodule
